// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and helpers for the multi-port register file.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width.
//   reset_value()           : reset contents of register idx.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Reset contents of register idx: its own index when by_index is set,
  // otherwise zero. The caller resizes the result to its register width.
  function automatic logic [31:0] reset_value(input int unsigned idx, input bit by_index);
    return by_index ? idx : 32'd0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Per-register pending-write scoreboard used by decode for RAW hazard
//   detection.
//   clk, reset          : clock, asynchronous active-high reset
//   resv_en/resv_addr   : reserve a register for a future write
//   wr0_en/wr0_addr     : write port 0 (clears the reservation)
//   wr1_en/wr1_addr     : write port 1 (clears the reservation)
//   rd_addr             : packed read addresses, NUM_RD x ADDR_W
//   pending             : registered scoreboard vector, one bit per register
//   rd_busy             : per read port, addressed register still pending
module regfile_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [DEPTH-1:0]         pending,
  output logic [NUM_RD-1:0]        rd_busy
);

  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [DEPTH-1:0] pending_nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Register 0 is never reserved when it is hardwired to zero.
      set_vec[i] = resv_en && (resv_addr == ADDR_W'(i)) && !(ZERO_REG != 0 && i == 0);
      clr_vec[i] = (wr0_en && (wr0_addr == ADDR_W'(i))) ||
                   (wr1_en && (wr1_addr == ADDR_W'(i)));
    end
    // A reservation landing on the same edge as a write belongs to a newer
    // producer, so set dominates clear.
    pending_nxt = set_vec | (pending & ~clr_vec);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    logic [ADDR_W-1:0] addr;
    logic              wr_hit;

    assign addr   = rd_addr[k*ADDR_W +: ADDR_W];
    assign wr_hit = (wr0_en && (wr0_addr == addr)) || (wr1_en && (wr1_addr == addr));
    // A same-cycle write satisfies the hazard only when it is forwarded.
    assign rd_busy[k] = pending[addr] &&
                        !(BYPASS != 0 && wr_hit) &&
                        !(ZERO_REG != 0 && addr == '0);
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised multi-port register file: NUM_RD combinational read ports,
//   two write ports (port 1 wins on address collision), optional hardwired
//   zero register, optional write-to-read bypass, and a pending-write
//   scoreboard for decode-stage RAW hazard detection.
//   clk, reset                  : clock, asynchronous active-high reset
//   rd_addr / rd_data / rd_busy : packed read ports, NUM_RD wide
//   wr0_en/wr0_addr/wr0_data    : write port 0
//   wr1_en/wr1_addr/wr1_data    : write port 1, higher priority
//   resv_en / resv_addr         : reserve a register for a future write
//   pending                     : registered scoreboard vector
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_RD      = 2,
  parameter int ZERO_REG    = 1,
  parameter int RESET_INDEX = 1,
  parameter int BYPASS      = 1,
  localparam int DEPTH      = 2 ** ADDR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     resv_en,
  input  logic [ADDR_W-1:0]        resv_addr,
  output logic [DEPTH-1:0]         pending
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write enables qualified by reset: while reset is high nothing is
  // written, forwarded or allowed to clear a reservation.
  logic wr0_act;
  logic wr1_act;
  logic wr0_keep;
  logic wr1_keep;

  assign wr0_act  = wr0_en && !reset;
  assign wr1_act  = wr1_en && !reset;
  assign wr0_keep = wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
  assign wr1_keep = wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_W'(reset_value(i, RESET_INDEX != 0));
      end
    end else begin
      // Port 1 is assigned last so it wins when both ports hit one address.
      if (wr0_keep) mem[wr0_addr] <= wr0_data;
      if (wr1_keep) mem[wr1_addr] <= wr1_data;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = mem[addr];
      if (BYPASS != 0) begin
        if (wr1_act && (wr1_addr == addr)) begin
          data = wr1_data;
        end else if (wr0_act && (wr0_addr == addr)) begin
          data = wr0_data;
        end
      end
      // Zero forcing overrides any forwarded value.
      if (ZERO_REG != 0 && addr == '0) begin
        data = '0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .resv_en   (resv_en),
    .resv_addr (resv_addr),
    .wr0_en    (wr0_act),
    .wr0_addr  (wr0_addr),
    .wr1_en    (wr1_act),
    .wr1_addr  (wr1_addr),
    .rd_addr   (rd_addr),
    .pending   (pending),
    .rd_busy   (rd_busy)
  );

endmodule
